serial_sub_module: RTL and testbench

Bit-serial two's-complement subtractor. It computes D = A − B − Bin one bit per clock, LSB first, using a single full-subtractor cell with a registered borrow. It is the inverse arithmetic companion to the combinational full-adder cell and serves area-constrained datapaths where a WIDTH-wide ripple subtractor is too large. Operands load in parallel on a start pulse. The result, borrow and signed overflow are presented in parallel with a one-cycle done strobe.

---
 rtl/serial_sub_module.sv | 112 +++++++++++
 tb/tb_serial_sub_module.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/serial_sub_module.sv
// Bit-serial two's-complement subtractor: D = A - B - Bin, one bit per clock, LSB first.
// Operands load on start; D/Bout/V are registered on completion with a one-cycle done strobe.
module serial_sub_module #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_d_sr;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             r_sign_a;
  logic             r_sign_b;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;
  logic             r_v;

  logic             w_a;
  logic             w_b;
  logic             w_d;
  logic             w_br_nxt;
  logic             w_last;
  logic             w_accept;
  logic [WIDTH-1:0] w_d_final;

  // Single full-subtractor cell on the operand LSBs
  assign w_a       = r_a_sr[0];
  assign w_b       = r_b_sr[0];
  assign w_d       = w_a ^ w_b ^ r_br;
  assign w_br_nxt  = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);
  assign w_last    = (r_cnt == CW'(WIDTH - 1));
  assign w_d_final = {w_d, r_d_sr[WIDTH-1:1]};
  assign w_accept  = start && (r_state == S_IDLE || r_state == S_DONE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_d_sr   <= '0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_d      <= '0;
      r_bout   <= 1'b0;
      r_v      <= 1'b0;
    end else if (w_accept) begin
      r_a_sr   <= A;
      r_b_sr   <= B;
      r_br     <= Bin;
      r_cnt    <= '0;
      r_sign_a <= A[WIDTH-1];
      r_sign_b <= B[WIDTH-1];
    end else if (r_state == S_RUN) begin
      r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
      r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
      r_d_sr <= w_d_final;
      r_br   <= w_br_nxt;
      r_cnt  <= r_cnt + 1'b1;
      // Result outputs only move on the completion edge
      if (w_last) begin
        r_d    <= w_d_final;
        r_bout <= w_br_nxt;
        r_v    <= (r_sign_a ^ r_sign_b) & (r_sign_a ^ w_d);
      end
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign D    = r_d;
  assign Bout = r_bout;
  assign V    = r_v;

endmodule

// File: tb/tb_serial_sub_module.sv
// Self-checking bench for serial_sub_module (WIDTH=8): directed vectors, random operands,
// mid-run noise, reset abort and continuous-start throughput against an arithmetic model.
module tb_serial_sub_module;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic       Bin;
  logic       busy;
  logic       done;
  logic [7:0] D;
  logic       Bout;
  logic       V;

  int n_checks;
  int n_fail;
  int cyc;
  int last_done_cyc;

  logic [7:0] exp_d;
  logic       exp_bout;
  logic       exp_v;

  serial_sub_module #(.WIDTH(8)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .Bout  (Bout),
    .V     (V)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations
  task automatic model(input logic [7:0] a, input logic [7:0] b, input logic bin);
    int ua, ub, sa, sb, udiff, sdiff;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    udiff = ua - ub - int'(bin);
    sdiff = sa - sb - int'(bin);
    exp_d    = udiff[7:0];
    exp_bout = (udiff < 0);
    exp_v    = (sdiff < -128) || (sdiff > 127);
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       input bit noise, input bit keep_start, input bit check_period);
    A = a; B = b; Bin = bin; start = 1'b1;
    step();
    if (!keep_start) start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("busy_run", busy, 1);
      check("done_run", done, 0);
      check("d_hold", D, exp_d);
      if (noise) begin
        A   = 8'($urandom);
        B   = 8'($urandom);
        Bin = 1'($urandom);
        if (!keep_start) start = (i < 7) ? 1'($urandom) : 1'b0;
      end
      step();
    end
    model(a, b, bin);
    check("done_pulse", done, 1);
    check("busy_done", busy, 0);
    check("d_result", D, exp_d);
    check("bout_result", Bout, exp_bout);
    check("v_result", V, exp_v);
    if (check_period) check("done_period", cyc - last_done_cyc, 9);
    last_done_cyc = cyc;
    if (!keep_start) begin
      step();
      check("done_one_cycle", done, 0);
      check("busy_idle", busy, 0);
      check("d_idle_hold", D, exp_d);
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; last_done_cyc = 0;
    rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    exp_d = '0; exp_bout = 1'b0; exp_v = 1'b0;
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_d", D, 0);
    check("rst_bout", Bout, 0);
    check("rst_v", V, 0);
    rst = 1'b0;
    step();

    do_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    check("vec_5a_3c", D, 8'h1E);
    do_op(8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    check("vec_00_01_bout", Bout, 1);
    do_op(8'h80, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    check("vec_80_01_v", V, 1);
    do_op(8'h10, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0);
    check("vec_10_0f_1", D, 8'h00);
    do_op(8'h7F, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    check("vec_7f_ff", {Bout, V, D}, {2'b11, 8'h80});

    // Start pulses and operand toggling while busy must not disturb the result
    do_op(8'h5A, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
    check("noise_5a_3c", D, 8'h1E);

    for (int k = 0; k < 20; k++)
      do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0);

    // Reset during the 4th RUN cycle aborts the operation
    A = 8'h5A; B = 8'h3C; Bin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_d", D, 0);
    check("abort_bout", Bout, 0);
    check("abort_v", V, 0);
    exp_d = '0; exp_bout = 1'b0; exp_v = 1'b0;
    for (int i = 0; i < 12; i++) begin
      check("no_done_after_abort", done, 0);
      step();
    end
    do_op(8'h10, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0);

    // Simultaneous rst and start: reset wins
    rst = 1'b1; start = 1'b1; A = 8'h33; B = 8'h11;
    step();
    rst = 1'b0; start = 1'b0;
    check("rst_start_busy", busy, 0);
    check("rst_start_d", D, 0);
    exp_d = '0; exp_bout = 1'b0; exp_v = 1'b0;
    step();
    check("rst_start_idle", busy, 0);

    // start held high: back-to-back operations every 9 cycles
    do_op(8'h5A, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0);
    do_op(8'h00, 8'h01, 1'b0, 1'b1, 1'b1, 1'b1);
    do_op(8'h80, 8'h01, 1'b0, 1'b1, 1'b1, 1'b1);
    start = 1'b0;
    step();
    check("held_end_done", done, 0);
    check("held_end_busy", busy, 0);
    check("held_end_d", D, 8'h7F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
